// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared OpCode encodings and sizing helper for sync_fifo_param
package fifo_pkg;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RDWR  = 2'b11;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port storage, one write port and one registered read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int AW        = ptr_width(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-before-write: a same-address read+write (full FIFO) returns the old word.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised circular-buffer FIFO with count and sticky error flags
// Optional almost-full/almost-empty thresholds: define SYNC_FIFO_ALMOST_FLAGS_EN.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [1:0]              OpCode,
  input  logic [DATA_WIDTH-1:0]   Din,
  input  logic                    ClearErr,
  output logic [DATA_WIDTH-1:0]   Dout,
  output logic                    DoutValid,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    FifoFull,
  output logic                    FifoEmpty,
  output logic                    AlmostFull,
  output logic                    AlmostEmpty,
  output logic                    Overflow,
  output logic                    Underflow
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and at least 2");
  end
  if (AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_levels
    $error("sync_fifo_param: AF_LEVEL/AE_LEVEL must lie within 0..DEPTH");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          wr_req;
  logic          rd_req;
  logic          wr_accept;
  logic          rd_accept;
  logic          ovf_set;
  logic          udf_set;

  always_comb begin
    wr_req = 1'b0;
    rd_req = 1'b0;
    case (OpCode)
      OP_IDLE:  ;
      OP_WRITE: wr_req = 1'b1;
      OP_READ:  rd_req = 1'b1;
      OP_RDWR: begin
        wr_req = 1'b1;
        rd_req = 1'b1;
      end
      default:  ;
    endcase
  end

  // A full FIFO still takes a write when the same edge frees a slot; an empty
  // FIFO never bypasses Din to the read side.
  assign rd_accept = rd_req && !FifoEmpty;
  assign wr_accept = wr_req && (!FifoFull || rd_accept);
  assign ovf_set   = wr_req && !wr_accept;
  assign udf_set   = rd_req && !rd_accept;

  always_comb begin
    count_next = Count;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = Count + CW'(1);
      2'b01:   count_next = Count - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      Count     <= '0;
      FifoFull  <= 1'b0;
      FifoEmpty <= 1'b1;
      DoutValid <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      Count     <= count_next;
      FifoFull  <= (count_next == CW'(DEPTH));
      FifoEmpty <= (count_next == '0);
      DoutValid <= rd_accept;
    end
  end

  // A new error in the same cycle as ClearErr leaves the flag set.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Overflow  <= ovf_set | (Overflow  & ~ClearErr);
      Underflow <= udf_set | (Underflow & ~ClearErr);
    end
  end

`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      AlmostFull  <= 1'b0;
      AlmostEmpty <= 1'b1;
    end else begin
      AlmostFull  <= (count_next >= CW'(AF_LEVEL));
      AlmostEmpty <= (count_next <= CW'(AE_LEVEL));
    end
  end
`else
  assign AlmostFull  = 1'b0;
  assign AlmostEmpty = 1'b0;
`endif

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .Clk     (Clk),
    .Reset   (Reset),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (Din),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr),
    .rd_data (Dout)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed table-driven bench for sync_fifo_param (DEPTH=16, 32-bit)
module tb_sync_fifo_param;
  import fifo_pkg::*;

`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  localparam bit ALMOST_EN = 1'b1;
`else
  localparam bit ALMOST_EN = 1'b0;
`endif

  logic        Clk;
  logic        Reset;
  logic [1:0]  OpCode;
  logic [31:0] Din;
  logic        ClearErr;
  logic [31:0] Dout;
  logic        DoutValid;
  logic [4:0]  Count;
  logic        FifoFull, FifoEmpty, AlmostFull, AlmostEmpty, Overflow, Underflow;

  int errors = 0;
  int checks = 0;

  sync_fifo_param #(.DATA_WIDTH(32), .DEPTH(16)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .OpCode      (OpCode),
    .Din         (Din),
    .ClearErr    (ClearErr),
    .Dout        (Dout),
    .DoutValid   (DoutValid),
    .Count       (Count),
    .FifoFull    (FifoFull),
    .FifoEmpty   (FifoEmpty),
    .AlmostFull  (AlmostFull),
    .AlmostEmpty (AlmostEmpty),
    .Overflow    (Overflow),
    .Underflow   (Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] din;
    logic        clr;
    logic [31:0] dout;
    logic        dv;
    logic [4:0]  cnt;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] din, input logic clr,
                              input logic [31:0] dout, input logic dv, input int cnt,
                              input logic ovf, input logic udf);
    vec_t v;
    v.op    = op;
    v.din   = din;
    v.clr   = clr;
    v.dout  = dout;
    v.dv    = dv;
    v.cnt   = 5'(cnt);
    v.full  = (cnt == 16);
    v.empty = (cnt == 0);
    v.af    = ALMOST_EN && (cnt >= 14);
    v.ae    = ALMOST_EN && (cnt <= 2);
    v.ovf   = ovf;
    v.udf   = udf;
    return v;
  endfunction

  task automatic chk(input string tag, input int idx, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] %s: got 0x%0h expected 0x%0h", tag, idx, what, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input vec_t v);
    chk(tag, idx, "Dout",        Dout,        v.dout);
    chk(tag, idx, "DoutValid",   DoutValid,   v.dv);
    chk(tag, idx, "Count",       Count,       v.cnt);
    chk(tag, idx, "FifoFull",    FifoFull,    v.full);
    chk(tag, idx, "FifoEmpty",   FifoEmpty,   v.empty);
    chk(tag, idx, "AlmostFull",  AlmostFull,  v.af);
    chk(tag, idx, "AlmostEmpty", AlmostEmpty, v.ae);
    chk(tag, idx, "Overflow",    Overflow,    v.ovf);
    chk(tag, idx, "Underflow",   Underflow,   v.udf);
  endtask

  task automatic apply(input vec_t v);
    OpCode   = v.op;
    Din      = v.din;
    ClearErr = v.clr;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; OpCode = OP_IDLE; Din = '0; ClearErr = 1'b0;
    #2;
    check_outs("reset", 0, mk(OP_IDLE, 0, 0, 32'h0, 0, 0, 0, 0));
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_outs("idle", 0, mk(OP_IDLE, 0, 0, 32'h0, 0, 0, 0, 0));

    // Fill, overflow, drain in order
    for (int i = 1; i <= 16; i++) vecs.push_back(mk(OP_WRITE, i, 0, 32'h0, 0, i, 0, 0));
    vecs.push_back(mk(OP_WRITE, 32'hFF, 0, 32'h0, 0, 16, 1, 0));
    for (int k = 1; k <= 16; k++) vecs.push_back(mk(OP_READ, 0, 0, k, 1, 16 - k, 1, 0));
    // Underflow, then clear of both sticky flags
    vecs.push_back(mk(OP_READ, 0, 0, 32'h10, 0, 0, 1, 1));
    vecs.push_back(mk(OP_IDLE, 0, 1, 32'h10, 0, 0, 0, 0));
    vecs.push_back(mk(OP_IDLE, 0, 0, 32'h10, 0, 0, 0, 0));
    // Full with simultaneous read+write
    for (int i = 1; i <= 16; i++) vecs.push_back(mk(OP_WRITE, i, 0, 32'h10, 0, i, 0, 0));
    for (int j = 0; j < 8; j++) vecs.push_back(mk(OP_RDWR, 32'hA0 + j, 0, j + 1, 1, 16, 0, 0));
    for (int k = 0; k < 8; k++) vecs.push_back(mk(OP_READ, 0, 0, 9 + k, 1, 15 - k, 0, 0));
    for (int k = 0; k < 8; k++) vecs.push_back(mk(OP_READ, 0, 0, 32'hA0 + k, 1, 7 - k, 0, 0));
    // Read+write on empty: write only, no bypass; clear coinciding with new error
    vecs.push_back(mk(OP_RDWR, 32'h55, 0, 32'hA7, 0, 1, 0, 1));
    vecs.push_back(mk(OP_READ, 0, 0, 32'h55, 1, 0, 0, 1));
    vecs.push_back(mk(OP_READ, 0, 1, 32'h55, 0, 0, 0, 1));
    vecs.push_back(mk(OP_IDLE, 0, 1, 32'h55, 0, 0, 0, 0));
    // Pointer wrap
    for (int i = 0; i < 10; i++) vecs.push_back(mk(OP_WRITE, 32'hB0 + i, 0, 32'h55, 0, i + 1, 0, 0));
    for (int k = 0; k < 10; k++) vecs.push_back(mk(OP_READ, 0, 0, 32'hB0 + k, 1, 9 - k, 0, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(OP_WRITE, 32'hC0 + i, 0, 32'hB9, 0, i + 1, 0, 0));
    for (int k = 0; k < 10; k++) vecs.push_back(mk(OP_READ, 0, 0, 32'hC0 + k, 1, 9 - k, 0, 0));

    for (int n = 0; n < vecs.size(); n++) begin
      apply(vecs[n]);
      check_outs("vec", n, vecs[n]);
    end

    // Asynchronous reset mid-burst at Count=7
    for (int i = 0; i < 7; i++) apply(mk(OP_WRITE, 32'hE0 + i, 0, 0, 0, 0, 0, 0));
    check_outs("burst", 0, mk(OP_IDLE, 0, 0, 32'hC9, 0, 7, 0, 0));
    #2;
    Reset = 1'b1;
    #1;
    check_outs("midrst", 0, mk(OP_IDLE, 0, 0, 32'h0, 0, 0, 0, 0));
    @(negedge Clk);
    Reset = 1'b0;
    apply(mk(OP_WRITE, 32'hD1, 0, 0, 0, 0, 0, 0));
    check_outs("postrst", 0, mk(OP_IDLE, 0, 0, 32'h0, 0, 1, 0, 0));
    apply(mk(OP_READ, 0, 0, 0, 0, 0, 0, 0));
    check_outs("postrst", 1, mk(OP_IDLE, 0, 0, 32'hD1, 1, 0, 0, 0));
    apply(mk(OP_READ, 0, 0, 0, 0, 0, 0, 0));
    check_outs("postrst", 2, mk(OP_IDLE, 0, 0, 32'hD1, 0, 0, 0, 1));
    OpCode = OP_IDLE;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
